// File: rtl/ks_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ks_sched_pkg
//  Brief    : Shared types, constants and round-robin search for the
//             nibble-serial Kogge-Stone add scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package ks_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the shared adder slice
    localparam int NIB_W   = 4;
    // Largest requester count the grant search is written for
    localparam int MAX_REQ = 8;

    // Returns the first requester index with valid set, searching upward
    // from last+1 and wrapping at nreq; returns -1 when nobody is requesting.
    function automatic int rr_next_grant(
        input logic [MAX_REQ-1:0] valid,
        input int                 last,
        input int                 nreq
    );
        int res;
        int idx;
        res = -1;
        // Walk from farthest to nearest so the nearest hit is the one kept
        for (int k = MAX_REQ; k >= 1; k--) begin
            idx = (last + k) % nreq;
            if ((k <= nreq) && valid[idx[2:0]]) begin
                res = idx;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ks_adder4.sv
`default_nettype none
// ============================================================================
//  Module   : ks_adder4
//  Brief    : 4-bit Kogge-Stone adder (generate/propagate, two prefix
//             levels, sum XOR). Purely combinational.
//  Revision : 1.0 - initial release
// ============================================================================
module ks_adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_g0;
    logic [3:0] w_g1;
    logic [3:2] w_p1;
    logic [3:0] w_g2;

    // Prefix tree; carry-in is folded into bit 0 generate so every prefix
    // generate term is directly the carry out of its bit.
    always_comb begin
        w_g  = a & b;
        w_p  = a ^ b;
        w_g0 = w_g;
        w_g0[0] = w_g[0] | (w_p[0] & cin);

        // Level 1: span 2
        w_g1 = w_g0;
        w_p1 = '0;
        for (int i = 1; i < 4; i++) begin
            w_g1[i] = w_g0[i] | (w_p[i] & w_g0[i-1]);
        end
        for (int i = 2; i < 4; i++) begin
            w_p1[i] = w_p[i] & w_p[i-1];
        end

        // Level 2: span 4
        w_g2 = w_g1;
        for (int i = 2; i < 4; i++) begin
            w_g2[i] = w_g1[i] | (w_p1[i] & w_g1[i-2]);
        end

        s    = w_p ^ {w_g2[2:0], cin};
        cout = w_g2[3];
    end

endmodule
`default_nettype wire

// File: rtl/ks_add_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : ks_add_scheduler
//  Brief    : Round-robin arbiter that runs each granted WIDTH-bit add
//             through a single shared 4-bit Kogge-Stone adder, one nibble
//             per cycle, and returns the sum over a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module ks_add_scheduler
    import ks_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*WIDTH-1:0]    req_a,
    input  logic [NREQ*WIDTH-1:0]    req_b,
    input  logic [NREQ-1:0]          req_cin,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic                     busy
);

    localparam int NNIB  = WIDTH / NIB_W;
    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [CNT_W-1:0] C_LAST_NIB  = CNT_W'(NNIB - 1);
    localparam logic [ID_W-1:0]  C_LAST_INIT = ID_W'(NREQ - 1);

    state_e              state_q;
    logic [ID_W-1:0]     last_grant_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [WIDTH-1:0]    sum_q;
    logic                carry_q;
    logic [CNT_W-1:0]    nib_q;
    logic [ID_W-1:0]     id_q;
    logic                rsp_cout_q;
    logic                rsp_valid_q;
    logic                busy_q;

    int                  w_grant_idx;
    logic                w_found;
    logic [ID_W-1:0]     w_grant;
    logic [WIDTH-1:0]    w_op_a;
    logic [WIDTH-1:0]    w_op_b;
    logic [NIB_W-1:0]    w_nib_a;
    logic [NIB_W-1:0]    w_nib_b;
    logic [NIB_W-1:0]    w_nib_s;
    logic                w_nib_cout;

    // Round-robin search starting just after the last served requester
    always_comb begin
        w_grant_idx = rr_next_grant(MAX_REQ'(req_valid), int'(last_grant_q), NREQ);
        w_found     = (w_grant_idx >= 0);
        w_grant     = ID_W'(w_grant_idx);
        w_op_a      = req_a[w_grant*WIDTH +: WIDTH];
        w_op_b      = req_b[w_grant*WIDTH +: WIDTH];
    end

    // Accept strobe is combinational so the requester sees it in the grant cycle
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == IDLE) && w_found) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    // Current nibble of the latched operands feeds the shared adder
    always_comb begin
        w_nib_a = a_q[nib_q*NIB_W +: NIB_W];
        w_nib_b = b_q[nib_q*NIB_W +: NIB_W];
    end

    ks_adder4 u_adder (
        .a    (w_nib_a),
        .b    (w_nib_b),
        .cin  (carry_q),
        .s    (w_nib_s),
        .cout (w_nib_cout)
    );

    // Control FSM with registered datapath and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= C_LAST_INIT;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            carry_q      <= 1'b0;
            nib_q        <= '0;
            id_q         <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_found) begin
                        a_q     <= w_op_a;
                        b_q     <= w_op_b;
                        carry_q <= req_cin[w_grant];
                        id_q    <= w_grant;
                        nib_q   <= '0;
                        sum_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[nib_q*NIB_W +: NIB_W] <= w_nib_s;
                    carry_q <= w_nib_cout;
                    if (nib_q == C_LAST_NIB) begin
                        rsp_cout_q  <= w_nib_cout;
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        nib_q <= nib_q + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q  <= 1'b0;
                        busy_q       <= 1'b0;
                        last_grant_q <= id_q;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = id_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ks_add_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ks_add_scheduler
//  Brief    : Scoreboard bench for ks_add_scheduler (NREQ=4, WIDTH=16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ks_add_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic [1:0]            rsp_id;
    logic                  busy;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] sum;
        logic        cout;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    ks_add_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one requester's operands and raise its valid
    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic cin);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_cin[i]              = cin;
        req_valid[i]            = 1'b1;
    endtask

    task automatic push(input int id, input logic [15:0] sum, input logic cout);
        exp_t e;
        e.id   = 2'(id);
        e.sum  = sum;
        e.cout = cout;
        sb.push_back(e);
    endtask

    // Wait (bounded) for a grant; returns the granted index, leaves time at edge+1
    task automatic wait_accept(output int id);
        id = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                check("ready_onehot", 32'($countones(req_ready)), 32'd1);
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) id = i;
                @(posedge clk); #1;
                check("ready_pulse", 32'(req_ready), 32'd0);
                return;
            end
        end
        errors++;
        $display("FAIL accept_timeout: got no grant expected a grant");
    endtask

    // Wait (bounded) for rsp_valid; returns edges counted, leaves time at edge+1
    task automatic wait_valid(output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            n++;
            if (rsp_valid) return;
        end
        errors++;
        $display("FAIL valid_timeout: got no rsp_valid expected rsp_valid");
    endtask

    // One complete transaction on a single requester with rsp_ready high
    task automatic single(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic [15:0] s, input logic c);
        int id;
        int n;
        push(i, s, c);
        set_req(i, a, b, cin);
        wait_accept(id);
        req_valid[i] = 1'b0;
        check("grant_id", 32'(id), 32'(i));
        check("busy_after_accept", 32'(busy), 32'd1);
        wait_valid(n);
        check("latency", 32'(n), 32'd4);
        @(posedge clk); #1;
        check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        check("busy_after_hs", 32'(busy), 32'd0);
    endtask

    // Monitor: every response handshake pops and compares the next expectation
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_rsp: got id %0d sum %0h expected none", rsp_id, rsp_sum);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_sum", 32'(rsp_sum), 32'(e.sum));
                check("rsp_cout", 32'(rsp_cout), 32'(e.cout));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int id;
        int n;
        int cnt[NREQ];
        int order[8];
        order = '{0, 1, 2, 3, 0, 1, 2, 3};
        foreach (cnt[i]) cnt[i] = 0;

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        check("rst_rsp_cout", 32'(rsp_cout), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Inter-nibble carry
        single(0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
        // Wrap-around vectors on req3 so round-robin restarts at 0 afterwards
        single(3, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        single(3, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
        single(3, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);

        // Round-robin: all four requesting, each drops after its second grant
        for (int k = 0; k < 8; k++) begin
            case (order[k])
                0: push(0, 16'h3333, 1'b0);
                1: push(1, 16'h0000, 1'b1);
                2: push(2, 16'h1001, 1'b0);
                default: push(3, 16'h0001, 1'b1);
            endcase
        end
        set_req(0, 16'h1111, 16'h2222, 1'b0);
        set_req(1, 16'hF000, 16'h1000, 1'b0);
        set_req(2, 16'h0F0F, 16'h00F1, 1'b1);
        set_req(3, 16'h8000, 16'h8000, 1'b1);
        for (int k = 0; k < 8; k++) begin
            wait_accept(id);
            check("rr_order", 32'(id), 32'(order[k]));
            if (id >= 0) begin
                cnt[id]++;
                if (cnt[id] == 2) req_valid[id] = 1'b0;
            end
        end
        wait_valid(n);
        @(posedge clk); #1;

        // Backpressure: response held for 10 cycles while req0 waits
        rsp_ready = 1'b0;
        push(3, 16'h8000, 1'b0);
        push(0, 16'h0001, 1'b0);
        set_req(3, 16'h7FFF, 16'h0001, 1'b0);
        wait_accept(id);
        req_valid[3] = 1'b0;
        check("bp_grant", 32'(id), 32'd3);
        wait_valid(n);
        set_req(0, 16'h0000, 16'h0000, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_sum", 32'(rsp_sum), 32'h8000);
            check("bp_id", 32'(rsp_id), 32'd3);
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_no_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_busy", 32'(busy), 32'd0);
        check("bp_idle_valid", 32'(rsp_valid), 32'd0);
        check("bp_idle_ready", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        check("bp_next_accept", 32'(busy), 32'd1);
        req_valid[0] = 1'b0;
        wait_valid(n);
        @(posedge clk); #1;

        // Reset during nibble 2 of a req2 operation
        push(2, 16'hBCDE, 1'b0);
        set_req(2, 16'hABCD, 16'h1111, 1'b0);
        wait_accept(id);
        req_valid[2] = 1'b0;
        check("mr_grant", 32'(id), 32'd2);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_req_ready", 32'(req_ready), 32'd0);
        check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mr_rsp_sum", 32'(rsp_sum), 32'd0);
        check("mr_rsp_cout", 32'(rsp_cout), 32'd0);
        check("mr_rsp_id", 32'(rsp_id), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        void'(sb.pop_back());
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(1, 16'h0003, 1'b0);
        push(2, 16'hBCDE, 1'b0);
        set_req(1, 16'h0001, 16'h0002, 1'b0);
        set_req(2, 16'hABCD, 16'h1111, 1'b0);
        wait_accept(id);
        req_valid[1] = 1'b0;
        check("mr_first", 32'(id), 32'd1);
        wait_accept(id);
        req_valid[2] = 1'b0;
        check("mr_second", 32'(id), 32'd2);

        // Drain and watch for any extra responses
        for (int k = 0; k < 60 && sb.size() != 0; k++) @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ks_add_scheduler.md
# ks_add_scheduler

Shares one 4-bit Kogge-Stone adder between `NREQ` requesters. Each requester submits a `WIDTH`-bit add. The block arbitrates round-robin, then runs the granted operation through the adder one nibble per cycle, holding the carry in a flop. It returns a registered sum with a valid/ready handshake. It sits between the requesting datapath blocks and the single shared `ks_adder4` instance.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 16: operand width; must be a multiple of 4. Define `NNIB = WIDTH/4`.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `req_valid`  in  NREQ: per-requester request.
- `req_ready`  out  NREQ: per-requester accept; one-hot or zero.
- `req_a`  in  NREQ*WIDTH: operand A; requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `req_b`  in  NREQ*WIDTH: operand B, same packing.
- `req_cin`  in  NREQ: carry-in per requester.
- `rsp_valid`  out  1: result available.
- `rsp_ready`  in  1: consumer accepts the result.
- `rsp_sum`  out  WIDTH: sum, modulo 2^WIDTH.
- `rsp_cout`  out  1: carry out of the MSB nibble.
- `rsp_id`  out  `$clog2(NREQ)`: index of the granted requester.
- `busy`  out  1: high in RUN and DONE.

## Operation
- **FSM states:** IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE:**
  - The grant is the first index with `req_valid` high, searching from `last_grant+1` modulo `NREQ`.
  - `req_ready[grant]` is driven combinationally in the same cycle.
  - At the edge, the block latches A, B and cin into operand registers, latches the id, sets `nib=0` and `carry=cin`, and moves to RUN.
  - With no `req_valid` high, the block stays in IDLE and all `req_ready` bits are 0.
- **RUN:**
  - Each cycle, `ks_adder4` adds nibble `nib` of A and B with `carry`.
  - The 4-bit result is written into `sum_q[nib*4 +: 4]`, `carry` takes the adder cout, and `nib` increments.
  - After nibble `NNIB-1`, the block moves to DONE and sets `rsp_cout` from the final carry.
- **DONE:**
  - `rsp_valid=1`.
  - `rsp_sum`, `rsp_cout` and `rsp_id` stay stable until `rsp_valid && rsp_ready` at an edge.
  - At that edge the block moves to IDLE and `last_grant` takes the value of `rsp_id`.
- `req_ready` is 0 in RUN and DONE.
- **Requester rules:**
  - Once `req_valid[i]` is asserted, it must stay high until accepted, with A, B and cin held stable.
  - Dropping `req_valid[i]` before acceptance is a protocol violation; the block's behaviour is then undefined.
- **Width rules:** the sum wraps modulo 2^WIDTH. `rsp_cout` is the true carry of A+B+cin. No overflow flag is produced.
- **Reset mid-operation:**
  - Asserting `rst_n` low at any point clears the FSM to IDLE and sets `last_grant=NREQ-1`.
  - All outputs reset to 0.
  - The in-flight operation is discarded; no response is ever produced for it.

## Timing
- **Reset values:** `req_ready=0`, `rsp_valid=0`, `rsp_sum=0`, `rsp_cout=0`, `rsp_id=0`, `busy=0`. After reset, requester 0 has top priority.
- **Latency:**
  - Acceptance happens at edge E0.
  - Nibble k is registered at edge E0+k+1.
  - `rsp_valid` goes high after edge E0+NNIB, which is 4 cycles for `WIDTH=16`.
- **Throughput:**
  - The earliest next acceptance is the edge one cycle after the response handshake (one IDLE cycle).
  - Minimum spacing between acceptances is `NNIB+2` cycles.
- **Simultaneous requests:** several `req_valid` bits high in the same cycle produce exactly one grant per round-robin rule; the losers keep waiting.
- `rsp_ready` held high while entering DONE gives a response lasting exactly one cycle.
- `busy` rises the cycle after acceptance and falls the cycle after the response handshake.

## Structure
- **Package `ks_sched_pkg`:**
  - state enum `{IDLE, RUN, DONE}`;
  - constant `NIB_W = 4`;
  - a function for the round-robin next-grant search.
- **Sub-module `ks_adder4`:**
  - ports: `a[3:0]`, `b[3:0]`, `cin`, `s[3:0]`, `cout`;
  - purely combinational: generate/propagate, then two Kogge-Stone prefix levels, then the sum XOR.
  - Instantiated exactly once.

## Test plan
- **Single add with inter-nibble carry:** req0 with A=16'h00FF, B=16'h0001, cin=0 -> `rsp_sum=16'h0100`, `rsp_cout=0`, `rsp_id=0`; `rsp_valid` rises exactly 4 cycles after acceptance.
- **Wrap-around:** A=16'hFFFF, B=16'h0001, cin=0 -> sum 16'h0000, cout 1. Then A=16'hFFFF, B=16'h0000, cin=1 -> 16'h0000, cout 1. Then A=16'h1234, B=16'h4321, cin=1 -> 16'h5556, cout 0.
- **Round-robin fairness:** all four `req_valid` held high continuously -> grants in order 0,1,2,3,0,1; each `req_ready` pulse lasts one cycle and is one-hot.
- **Backpressure:** `rsp_ready` held low for 10 cycles in DONE -> `rsp_valid`, `rsp_sum` and `rsp_id` stay stable, `busy=1`, no `req_ready` asserted. Releasing `rsp_ready` -> IDLE at the next edge; the next acceptance follows one cycle later.
- **Reset mid-RUN:** pull `rst_n` low during nibble 2 of a req2 operation -> all outputs read 0 immediately, without waiting for a clock edge. After release, with req1 and req2 both valid, req1 wins. No stale response for req2 ever appears.
